// File: rtl/disp_arbiter.sv
// Time-slice arbiter sharing the hex display between two data sources.
// Round-robin grant with minimum hold, optional lock and a blanked gap between owners.
module disp_arbiter #(
  parameter int DW         = 16,
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          lock,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] disp_data,
  output logic          disp_blank,
  output logic          owner
);

  localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int GW = (GAP_TICKS  < 1) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t        state;
  logic          rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;

  logic req_ptr, req_alt, pick, hold_done, gap_done;

  // Preferred requester is rr_ptr; pick is the index granted if anyone requests.
  assign req_ptr   = rr_ptr ? req1 : req0;
  assign req_alt   = rr_ptr ? req0 : req1;
  assign pick      = req_ptr ? rr_ptr : ~rr_ptr;
  assign hold_done = (hold_cnt == HOLD_MAX);
  assign gap_done  = (GAP_TICKS == 0) || (gap_cnt == GAP_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      disp_data  <= '0;
      disp_blank <= 1'b1;
    end else begin
      disp_blank <= !(state == OWN0 || state == OWN1);
      unique case (state)
        OWN0: begin
          disp_data <= data0;
          if (!req0 || (hold_done && req1 && !lock)) begin
            state   <= GAP;
            gnt0    <= 1'b0;
            gap_cnt <= '0;
          end else if (tick && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OWN1: begin
          disp_data <= data1;
          if (!req1 || (hold_done && req0 && !lock)) begin
            state   <= GAP;
            gnt1    <= 1'b0;
            gap_cnt <= '0;
          end else if (tick && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        IDLE, GAP: begin
          if (state == GAP && !gap_done) begin
            if (tick) gap_cnt <= gap_cnt + 1'b1;
          end else if (req_ptr || req_alt) begin
            state    <= pick ? OWN1 : OWN0;
            gnt0     <= ~pick;
            gnt1     <= pick;
            owner    <= pick;
            rr_ptr   <= ~pick;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
